// File: rtl/basic_system_nios2_cpu_debug_ocimem.sv
// On-chip debug monitor RAM: serves debug-slave read/write commands and a CPU Avalon slave
// on one single-port synchronous RAM. Debug traffic always wins arbitration.
module basic_system_nios2_cpu_debug_ocimem #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [37:0]         jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_no_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    output logic [31:0]         MonDReg,
    output logic                debug_busy,
    input  logic [ADDR_W-1:0]   address,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic [3:0]          byteenable,
    output logic [31:0]         readdata,
    output logic                waitrequest
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DBG_CAPTURE = 2'd1,
        CPU_RD_DATA = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_dbg_addr;
    logic                r_rd_pend;
    logic                r_wr_pend;
    logic [DATA_W-1:0]   r_wr_data;
    logic [DATA_W-1:0]   r_mon_dreg;
    logic [DATA_W-1:0]   r_readdata;
    logic [DATA_W-1:0]   r_ram_q;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_dbg_wr;
    logic                w_dbg_rd;
    logic                w_cpu_wr;
    logic                w_cpu_rd;
    logic                w_ram_we;
    logic                w_ram_re;
    logic [ADDR_W-1:0]   w_ram_addr;
    logic [DATA_W-1:0]   w_ram_wdata;
    logic [BE_W-1:0]     w_ram_be;
    logic                w_rd_set;
    logic                w_unused_jdo;

    assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};
    assign w_rd_set     = take_no_action_ocimem_a | (take_action_ocimem_a & jdo[35]);

    // Arbitration: pending debug write, pending debug read, CPU write, CPU read.
    always_comb begin
        w_dbg_wr = 1'b0;
        w_dbg_rd = 1'b0;
        w_cpu_wr = 1'b0;
        w_cpu_rd = 1'b0;
        if (r_state == IDLE) begin
            if (r_wr_pend) begin
                w_dbg_wr = 1'b1;
            end else if (r_rd_pend) begin
                w_dbg_rd = 1'b1;
            end else if (write) begin
                w_cpu_wr = reset_n;
            end else if (read) begin
                w_cpu_rd = reset_n;
            end
        end
    end

    assign w_ram_we    = w_dbg_wr | w_cpu_wr;
    assign w_ram_re    = w_dbg_rd | w_cpu_rd;
    assign w_ram_addr  = (w_dbg_wr | w_dbg_rd) ? r_dbg_addr : address;
    assign w_ram_wdata = w_dbg_wr ? r_wr_data : writedata;
    assign w_ram_be    = w_dbg_wr ? {BE_W{1'b1}} : byteenable;

    // CPU is granted only on an accepted write or the read-data cycle.
    assign waitrequest = ~(w_cpu_wr | ((r_state == CPU_RD_DATA) & reset_n));
    assign debug_busy  = r_wr_pend | r_rd_pend | (r_state == DBG_CAPTURE);
    assign MonDReg     = r_mon_dreg;
    assign readdata    = (r_state == CPU_RD_DATA) ? r_ram_q : r_readdata;

    // Single-port RAM with byte lanes and one-cycle registered read.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (w_ram_be[i]) begin
                    r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
                end
            end
        end
        if (w_ram_re) begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_dbg_addr <= '0;
            r_rd_pend  <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_wr_data  <= '0;
            r_mon_dreg <= '0;
            r_readdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_dbg_rd) begin
                        r_state <= DBG_CAPTURE;
                    end else if (w_cpu_rd) begin
                        r_state <= CPU_RD_DATA;
                    end
                end
                DBG_CAPTURE: begin
                    r_mon_dreg <= r_ram_q;
                    r_state    <= IDLE;
                end
                CPU_RD_DATA: begin
                    r_readdata <= r_ram_q;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            // A new pulse in the service cycle keeps the flag set.
            if (w_rd_set) begin
                r_rd_pend <= 1'b1;
            end else if (w_dbg_rd) begin
                r_rd_pend <= 1'b0;
            end

            if (take_action_ocimem_b) begin
                r_wr_pend <= 1'b1;
                r_wr_data <= jdo[34:3];
            end else if (w_dbg_wr) begin
                r_wr_pend <= 1'b0;
            end

            if (take_action_ocimem_a) begin
                r_dbg_addr <= jdo[26+ADDR_W-1:26];
            end else if (w_dbg_wr | w_dbg_rd) begin
                r_dbg_addr <= r_dbg_addr + ADDR_W'(1);
            end
        end
    end

endmodule
